// File: rtl/vect_issue_queue.sv
// vect_issue_queue: in-order issue queue between the scalar core and the vector lanes/LSU/SLDU.
// Define VIQ_BYPASS_EN to present a push into an empty queue on the issue port in the same cycle.
module vect_issue_queue #(
    parameter int  DATA_WIDTH = 32,
    parameter int  IQ_DEPTH   = 8,
    localparam int CNT_B      = $clog2(IQ_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] vinstr_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic                  vreq_i,
    output logic                  v_iq_ack_o,
    output logic                  v_iq_drop_o,
    output logic                  v_iq_full_o,
    output logic [CNT_B-1:0]      v_iq_count_o,
    output logic                  issue_valid_o,
    input  logic                  issue_ready_i,
    output logic [DATA_WIDTH-1:0] issue_instr_o,
    output logic [DATA_WIDTH-1:0] issue_rs1_o,
    output logic [DATA_WIDTH-1:0] issue_rs2_o,
    output logic [1:0]            issue_unit_o,
    input  logic                  lsu_done_i,
    output logic                  v_lsu_active_o,
    input  logic                  flush_i
);

    localparam int PTR_B = $clog2(IQ_DEPTH);

    localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
    localparam logic [6:0] OPC_VSTORE = 7'b0100111;
    localparam logic [6:0] OPC_OPV    = 7'b1010111;

    localparam logic [2:0] F3_OPMVV = 3'b010;
    localparam logic [2:0] F3_OPIVI = 3'b011;
    localparam logic [2:0] F3_OPIVX = 3'b100;
    localparam logic [2:0] F3_OPFVF = 3'b101;
    localparam logic [2:0] F3_OPMVX = 3'b110;
    localparam logic [2:0] F3_OPCFG = 3'b111;

    localparam logic [1:0] OFF_STRIDE = 2'b10;

    localparam logic [5:0] F6_VSLIDEUP   = 6'b001110;
    localparam logic [5:0] F6_VSLIDEDOWN = 6'b001111;
    localparam logic [5:0] F6_VADC       = 6'b010000;

    typedef enum logic [1:0] {
        UNIT_LANES = 2'd0,
        UNIT_LSU   = 2'd1,
        UNIT_SLDU  = 2'd2
    } unit_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] rs1;
        logic [DATA_WIDTH-1:0] rs2;
        unit_e                 unit;
    } entry_t;

    entry_t           mem_q [IQ_DEPTH];
    logic [PTR_B-1:0] wr_ptr_q;
    logic [PTR_B-1:0] rd_ptr_q;
    logic [CNT_B-1:0] count_q;
    logic             full_q;
    logic             ack_q;
    logic             drop_q;
    logic             lsu_active_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [5:0] funct6;
    logic [1:0] mop;
    logic       is_mem;
    logic       is_opv;
    entry_t     new_entry;

    assign opcode = vinstr_i[6:0];
    assign funct3 = vinstr_i[14:12];
    assign funct6 = vinstr_i[31:26];
    assign mop    = vinstr_i[27:26];
    assign is_mem = (opcode == OPC_VLOAD) || (opcode == OPC_VSTORE);
    assign is_opv = (opcode == OPC_OPV);

    // Decode of the incoming instruction into the entry that would be stored this cycle.
    always_comb begin
        // NOTE: every field gets a default first so no path through the branches leaves a latch.
        new_entry       = '0;
        new_entry.instr = vinstr_i;

        if (is_mem) begin
            new_entry.unit = UNIT_LSU;
        end else if (is_opv && funct3 != F3_OPCFG &&
                     (funct6 == F6_VSLIDEUP || funct6 == F6_VSLIDEDOWN)) begin
            new_entry.unit = UNIT_SLDU;
        end else if (is_opv && funct6 == F6_VADC &&
                     (funct3 == F3_OPMVV || funct3 == F3_OPMVX)) begin
            new_entry.unit = UNIT_SLDU;
        end else if (is_opv && funct3 == F3_OPMVV && funct6[5:3] == 3'b000) begin
            new_entry.unit = UNIT_SLDU;
        end else begin
            new_entry.unit = UNIT_LANES;
        end

        if (is_mem || (is_opv && (funct3 == F3_OPIVX || funct3 == F3_OPFVF ||
                                  funct3 == F3_OPMVV))) begin
            new_entry.rs1 = rs1_i;
        end else if (is_opv && funct3 == F3_OPIVI) begin
            new_entry.rs1 = {{(DATA_WIDTH-5){vinstr_i[19]}}, vinstr_i[19:15]};
        end

        if (is_mem && mop == OFF_STRIDE) begin
            new_entry.rs2 = rs2_i;
        end
    end

    logic       empty;
    entry_t     head;
    logic       lsu_stall;
    logic       head_valid;
    logic       push_req;
    logic       push_ok;
    logic       bypass;
    logic       dispatch;
    logic       store_push;
    logic       pop;
    logic [CNT_B-1:0] count_next;

    assign empty      = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign lsu_stall  = lsu_active_q && !lsu_done_i;
    assign head_valid = !empty && !(head.unit == UNIT_LSU && lsu_stall);
    assign push_req   = vreq_i && !flush_i;
    assign push_ok    = push_req && !full_q;

`ifdef VIQ_BYPASS_EN
    assign bypass = empty && push_ok && !(new_entry.unit == UNIT_LSU && lsu_stall);
`else
    assign bypass = 1'b0;
`endif

    assign issue_valid_o = head_valid || bypass;
    assign dispatch      = issue_valid_o && issue_ready_i && !flush_i;
    // A bypassed push that dispatches immediately never occupies a slot.
    assign store_push    = push_ok && !(bypass && issue_ready_i);
    assign pop           = dispatch && !bypass;
    assign count_next    = count_q + CNT_B'(store_push) - CNT_B'(pop);

    always_comb begin
        issue_instr_o = '0;
        issue_rs1_o   = '0;
        issue_rs2_o   = '0;
        issue_unit_o  = '0;
        if (bypass) begin
            issue_instr_o = new_entry.instr;
            issue_rs1_o   = new_entry.rs1;
            issue_rs2_o   = new_entry.rs2;
            issue_unit_o  = new_entry.unit;
        end else if (!empty) begin
            issue_instr_o = head.instr;
            issue_rs1_o   = head.rs1;
            issue_rs2_o   = head.rs2;
            issue_unit_o  = head.unit;
        end
    end

    // NOTE: payload storage has no reset; occupancy tracking alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (store_push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            ack_q        <= 1'b0;
            drop_q       <= 1'b0;
            lsu_active_q <= 1'b0;
        end else begin
            ack_q  <= push_ok;
            drop_q <= push_req && full_q;

            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                full_q   <= 1'b0;
            end else begin
                if (store_push) wr_ptr_q <= wr_ptr_q + PTR_B'(1);
                if (pop)        rd_ptr_q <= rd_ptr_q + PTR_B'(1);
                count_q <= count_next;
                full_q  <= (count_next == CNT_B'(IQ_DEPTH));
            end

            // A new LSU dispatch outranks a completion arriving in the same cycle.
            if (dispatch && issue_unit_o == UNIT_LSU) begin
                lsu_active_q <= 1'b1;
            end else if (lsu_done_i) begin
                lsu_active_q <= 1'b0;
            end
        end
    end

    assign v_iq_ack_o     = ack_q;
    assign v_iq_drop_o    = drop_q;
    assign v_iq_full_o    = full_q;
    assign v_iq_count_o   = count_q;
    assign v_lsu_active_o = lsu_active_q;

endmodule

// File: tb/tb_vect_issue_queue.sv
// Testbench for vect_issue_queue: directed sequences plus a random phase, checked against a
// reference scoreboard that predicts every dispatched entry and the status outputs each cycle.
module tb_vect_issue_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CNT_B = $clog2(DEPTH + 1);

    localparam logic [1:0] U_LANES = 2'd0;
    localparam logic [1:0] U_LSU   = 2'd1;
    localparam logic [1:0] U_SLDU  = 2'd2;

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [DW-1:0] rs1;
        logic [DW-1:0] rs2;
        logic [1:0]    unit;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [DW-1:0]    vinstr_i = '0;
    logic [DW-1:0]    rs1_i = '0;
    logic [DW-1:0]    rs2_i = '0;
    logic             vreq_i = 1'b0;
    logic             v_iq_ack_o;
    logic             v_iq_drop_o;
    logic             v_iq_full_o;
    logic [CNT_B-1:0] v_iq_count_o;
    logic             issue_valid_o;
    logic             issue_ready_i = 1'b0;
    logic [DW-1:0]    issue_instr_o;
    logic [DW-1:0]    issue_rs1_o;
    logic [DW-1:0]    issue_rs2_o;
    logic [1:0]       issue_unit_o;
    logic             lsu_done_i = 1'b0;
    logic             v_lsu_active_o;
    logic             flush_i = 1'b0;

    always #5 clk_i = ~clk_i;

    vect_issue_queue #(.DATA_WIDTH(DW), .IQ_DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .vinstr_i       (vinstr_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .vreq_i         (vreq_i),
        .v_iq_ack_o     (v_iq_ack_o),
        .v_iq_drop_o    (v_iq_drop_o),
        .v_iq_full_o    (v_iq_full_o),
        .v_iq_count_o   (v_iq_count_o),
        .issue_valid_o  (issue_valid_o),
        .issue_ready_i  (issue_ready_i),
        .issue_instr_o  (issue_instr_o),
        .issue_rs1_o    (issue_rs1_o),
        .issue_rs2_o    (issue_rs2_o),
        .issue_unit_o   (issue_unit_o),
        .lsu_done_i     (lsu_done_i),
        .v_lsu_active_o (v_lsu_active_o),
        .flush_i        (flush_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] opv(input logic [5:0] f6, input logic [2:0] f3,
                                        input logic [4:0] src1);
        return {f6, 1'b1, 5'd2, src1, f3, 5'd1, 7'b1010111};
    endfunction

    function automatic logic [31:0] vmem(input bit store, input logic [1:0] mop);
        return {3'b000, 1'b0, mop, 1'b1, 5'd3, 5'd5, 3'b111, 5'd4,
                store ? 7'b0100111 : 7'b0000111};
    endfunction

    // Independent reference decode of an instruction into its queue entry.
    function automatic exp_t ref_decode(input logic [DW-1:0] i, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
        exp_t e;
        logic ld_st, opv_op;
        logic [2:0] f3;
        logic [5:0] f6;
        ld_st  = (i[6:0] == 7'h07) || (i[6:0] == 7'h27);
        opv_op = (i[6:0] == 7'h57);
        f3     = i[14:12];
        f6     = i[31:26];
        e.instr = i;
        if (ld_st)                                                      e.unit = U_LSU;
        else if (opv_op && f3 != 3'd7 && (f6 == 6'd14 || f6 == 6'd15)) e.unit = U_SLDU;
        else if (opv_op && f6 == 6'd16 && (f3 == 3'd2 || f3 == 3'd6))  e.unit = U_SLDU;
        else if (opv_op && f3 == 3'd2 && f6 < 6'd8)                     e.unit = U_SLDU;
        else                                                            e.unit = U_LANES;
        if (ld_st || (opv_op && (f3 == 3'd4 || f3 == 3'd5 || f3 == 3'd2))) e.rs1 = a;
        else if (opv_op && f3 == 3'd3) e.rs1 = {{27{i[19]}}, i[19:15]};
        else                           e.rs1 = '0;
        e.rs2 = (ld_st && i[27:26] == 2'b10) ? b : '0;
        return e;
    endfunction

    exp_t sb[$];
    bit   m_known = 1'b0;
    bit   m_lsu = 1'b0;
    bit   exp_ack = 1'b0;
    bit   exp_drop = 1'b0;
    int   ack_seen = 0;
    int   drop_seen = 0;

    // Scoreboard: compare status against the model, pop/compare on dispatch, then advance.
    always @(negedge clk_i) begin
        exp_t ne, hd;
        bit vq, byp, ev, push_ok, pop, lsu_set, full_m;
        if (m_known) begin
            full_m = (sb.size() == DEPTH);
            check("ack", v_iq_ack_o, exp_ack);
            check("drop", v_iq_drop_o, exp_drop);
            check("count", v_iq_count_o, sb.size());
            check("full", v_iq_full_o, full_m);
            check("lsu_active", v_lsu_active_o, m_lsu);
            ne = ref_decode(vinstr_i, rs1_i, rs2_i);
            vq = 1'b0;
            if (sb.size() != 0) vq = !(sb[0].unit == U_LSU && m_lsu && !lsu_done_i);
            push_ok = vreq_i && !flush_i && !full_m;
            byp = 1'b0;
`ifdef VIQ_BYPASS_EN
            byp = (sb.size() == 0) && push_ok && !(ne.unit == U_LSU && m_lsu && !lsu_done_i);
`endif
            ev = vq || byp;
            check("issue_valid", issue_valid_o, ev);
            if (sb.size() == 0 && !byp) check("empty_payload", issue_instr_o, 0);
            pop = ev && issue_ready_i && !flush_i;
            lsu_set = 1'b0;
            if (pop) begin
                hd = byp ? ne : sb[0];
                check("issue_instr", issue_instr_o, hd.instr);
                check("issue_rs1", issue_rs1_o, hd.rs1);
                check("issue_rs2", issue_rs2_o, hd.rs2);
                check("issue_unit", issue_unit_o, hd.unit);
                lsu_set = (hd.unit == U_LSU);
            end
            if (v_iq_ack_o)  ack_seen++;
            if (v_iq_drop_o) drop_seen++;
            exp_ack  = push_ok;
            exp_drop = vreq_i && !flush_i && full_m;
            if (rst_i) begin
                sb.delete();
                m_lsu = 1'b0;
                exp_ack = 1'b0;
                exp_drop = 1'b0;
            end else begin
                if (flush_i) begin
                    sb.delete();
                end else begin
                    if (pop && !byp) void'(sb.pop_front());
                    if (push_ok && !(byp && pop)) sb.push_back(ne);
                end
                m_lsu = lsu_set ? 1'b1 : (lsu_done_i ? 1'b0 : m_lsu);
            end
        end else if (rst_i) begin
            m_known = 1'b1;
            sb.delete();
            m_lsu = 1'b0;
            exp_ack = 1'b0;
            exp_drop = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        vinstr_i = instr;
        rs1_i    = a;
        rs2_i    = b;
        vreq_i   = 1'b1;
        tick();
        vreq_i   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [31:0] itab [10];

    initial begin
        int a0, d0;
        itab[0] = opv(6'd0, 3'd0, 5'd3);
        itab[1] = opv(6'd0, 3'd3, 5'b10110);
        itab[2] = opv(6'd0, 3'd4, 5'd7);
        itab[3] = opv(6'd14, 3'd4, 5'd1);
        itab[4] = opv(6'd1, 3'd2, 5'd9);
        itab[5] = opv(6'd16, 3'd6, 5'd4);
        itab[6] = vmem(1'b0, 2'b00);
        itab[7] = vmem(1'b0, 2'b10);
        itab[8] = vmem(1'b1, 2'b10);
        itab[9] = opv(6'd9, 3'd5, 5'd2);

        // Reset and reset values
        repeat (2) tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_count", v_iq_count_o, 0);
        check("rst_full", v_iq_full_o, 0);
        check("rst_ack", v_iq_ack_o, 0);
        check("rst_drop", v_iq_drop_o, 0);
        check("rst_lsu", v_lsu_active_o, 0);
        check("rst_valid", issue_valid_o, 0);
        tick();

        // Fill to full, then one more push is dropped
        a0 = ack_seen;
        d0 = drop_seen;
        for (int i = 0; i < DEPTH; i++) push(opv(6'd0, 3'd0, 5'(i)), 32'(i), 32'(i + 100));
        push(opv(6'd0, 3'd0, 5'd31), 32'h99, 32'h98);
        @(negedge clk_i);
        check("full_count", v_iq_count_o, DEPTH);
        check("full_flag", v_iq_full_o, 1);
        check("full_drop_pulse", v_iq_drop_o, 1);
        tick();
        check("full_acks", ack_seen - a0, DEPTH);
        check("full_drops", drop_seen - d0, 1);

        // Pop and push on a full queue: pop happens, push dropped
        issue_ready_i = 1'b1;
        vinstr_i = opv(6'd0, 3'd0, 5'd30);
        vreq_i = 1'b1;
        tick();
        vreq_i = 1'b0;
        issue_ready_i = 1'b0;
        @(negedge clk_i);
        check("popfull_count", v_iq_count_o, DEPTH - 1);
        check("popfull_drop", v_iq_drop_o, 1);
        tick();
        issue_ready_i = 1'b1;
        repeat (DEPTH) tick();
        issue_ready_i = 1'b0;

        // Scalar operand selection
        push(opv(6'd0, 3'd3, 5'b11011), 32'hDEADBEEF, 32'h0);
        push(opv(6'd0, 3'd4, 5'd5), 32'h1234, 32'h5555);
        @(negedge clk_i);
        check("opivi_rs1", issue_rs1_o, 32'hFFFFFFFB);
        tick();
        issue_ready_i = 1'b1;
        tick();
        @(negedge clk_i);
        check("opivx_rs1", issue_rs1_o, 32'h1234);
        tick();
        issue_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) push(itab[i], 32'hA000 + 32'(i), 32'hB000 + 32'(i));
        issue_ready_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            lsu_done_i = ($urandom_range(0, 2) == 0);
            tick();
        end
        lsu_done_i = 1'b1;
        tick();
        lsu_done_i = 1'b0;
        issue_ready_i = 1'b0;

        // LSU hazard: second load waits for lsu_done
        push(vmem(1'b0, 2'b00), 32'h100, 32'h0);
        push(vmem(1'b0, 2'b00), 32'h200, 32'h0);
        issue_ready_i = 1'b1;
        tick();
        @(negedge clk_i);
        check("lsu_set", v_lsu_active_o, 1);
        check("lsu_held", issue_valid_o, 0);
        tick();
        lsu_done_i = 1'b1;
        @(negedge clk_i);
        check("lsu_release", issue_valid_o, 1);
        tick();
        lsu_done_i = 1'b0;
        @(negedge clk_i);
        check("lsu_still_active", v_lsu_active_o, 1);
        check("lsu_drained", v_iq_count_o, 0);
        tick();
        issue_ready_i = 1'b0;

        // Flush with a concurrent push; LSU state survives
        for (int i = 0; i < 5; i++) push(opv(6'd0, 3'd0, 5'(i)), 32'h0, 32'h0);
        flush_i = 1'b1;
        vreq_i = 1'b1;
        tick();
        flush_i = 1'b0;
        vreq_i = 1'b0;
        @(negedge clk_i);
        check("flush_count", v_iq_count_o, 0);
        check("flush_no_ack", v_iq_ack_o, 0);
        check("flush_lsu_kept", v_lsu_active_o, 1);
        tick();
        lsu_done_i = 1'b1;
        tick();
        lsu_done_i = 1'b0;

        // Push into an empty queue with the consumer ready
        issue_ready_i = 1'b1;
        vinstr_i = opv(6'd0, 3'd4, 5'd1);
        rs1_i = 32'h77;
        vreq_i = 1'b1;
        @(negedge clk_i);
`ifdef VIQ_BYPASS_EN
        check("empty_push_same", issue_valid_o, 1);
`else
        check("empty_push_same", issue_valid_o, 0);
`endif
        tick();
        vreq_i = 1'b0;
        @(negedge clk_i);
`ifdef VIQ_BYPASS_EN
        check("empty_push_next", v_iq_count_o, 0);
`else
        check("empty_push_next", issue_valid_o, 1);
`endif
        tick();
        @(negedge clk_i);
        check("empty_push_drain", v_iq_count_o, 0);
        tick();

        // Reset mid-operation
        push(vmem(1'b1, 2'b00), 32'h10, 32'h0);
        issue_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) push(opv(6'd0, 3'd0, 5'(i)), 32'h0, 32'h0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_count", v_iq_count_o, 0);
        check("midrst_lsu", v_lsu_active_o, 0);
        check("midrst_valid", issue_valid_o, 0);
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            vreq_i        = ($urandom_range(0, 2) != 0);
            vinstr_i      = itab[$urandom_range(0, 9)];
            rs1_i         = $urandom;
            rs2_i         = $urandom;
            issue_ready_i = ($urandom_range(0, 1) == 1);
            lsu_done_i    = ($urandom_range(0, 3) == 0);
            flush_i       = ($urandom_range(0, 39) == 0);
            tick();
        end
        vreq_i = 1'b0;
        flush_i = 1'b0;
        issue_ready_i = 1'b1;
        lsu_done_i = 1'b1;
        repeat (DEPTH + 4) tick();
        @(negedge clk_i);
        check("final_empty", v_iq_count_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
